// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: program_memory read port, redirect/control inputs
// and the IR/status outputs handed to decode.
//  slave  : the fetch unit (drives pc_addr, ir*, status; samples the rest)
//  master : the surrounding pipeline / memory / controller
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  pc_addr;
  logic [INSTR_W-1:0] mem_instr;
  logic               stall;
  logic               jmp;
  logic               call;
  logic               ret;
  logic [ADDR_W-1:0]  tgt;
  logic               halt_req;
  logic               resume;
  logic [INSTR_W-1:0] ir;
  logic [ADDR_W-1:0]  ir_pc;
  logic               ir_valid;
  logic               halted;
  logic               fault;
  logic               stk_ovf;

  modport slave (
    input  mem_instr, stall, jmp, call, ret, tgt, halt_req, resume,
    output pc_addr, ir, ir_pc, ir_valid, halted, fault, stk_ovf
  );

  modport master (
    output mem_instr, stall, jmp, call, ret, tgt, halt_req, resume,
    input  pc_addr, ir, ir_pc, ir_valid, halted, fault, stk_ovf
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, presents it to program_memory, latches the
// returned word into IR. Handles jmp/call/ret redirects (one-bubble penalty)
// through a small return-address stack, plus stall, halt/resume and fault.
// Ports:
//  clk     rising-edge clock
//  rst_n   synchronous active-low reset
//  bus     instr_fetch_unit_if.slave
//           pc_addr  -> fetch address (the PC register itself)
//           mem_instr<- combinational read data at pc_addr
//           stall/jmp/call/ret/tgt/halt_req/resume <- control
//           ir/ir_pc/ir_valid -> instruction register to decode
//           halted/fault/stk_ovf -> registered status
module instr_fetch_unit #(
  parameter int                 ADDR_W      = 12,
  parameter int                 INSTR_W     = 16,
  parameter int                 STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter logic [INSTR_W-1:0] NOP_WORD    = '1
) (
  input logic               clk,
  input logic               rst_n,
  instr_fetch_unit_if.slave bus
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;   // must be able to hold STACK_DEPTH itself

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HALT  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  logic [1:0]         state;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] ir_q;
  logic [ADDR_W-1:0]  ir_pc_q;
  logic               vld_q;
  logic               ovf_q;
  logic [SP_W-1:0]    sp;
  logic [ADDR_W-1:0]  stk [STACK_DEPTH];

  logic [SP_W-1:0]    sp_dec;
  logic [IDX_W-1:0]   push_idx;
  logic [IDX_W-1:0]   pop_idx;
  logic               stk_full;
  logic               stk_empty;
  logic               push_en;
  logic [ADDR_W-1:0]  ret_addr;

  always_comb begin
    sp_dec    = sp - 1'b1;
    push_idx  = sp[IDX_W-1:0];
    pop_idx   = sp_dec[IDX_W-1:0];
    stk_full  = (sp == SP_W'(STACK_DEPTH));
    stk_empty = (sp == '0);
    ret_addr  = ir_pc_q + ADDR_W'(1);
    // Push only when call is the winning action this cycle (halt_req and ret
    // outrank it) and there is room; an overflowing call just redirects.
    push_en   = rst_n && (state == ST_RUN) && !bus.halt_req && !bus.ret &&
                bus.call && !stk_full;
  end

  // Stack storage carries no reset: SP alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push_en) stk[push_idx] <= ret_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_RUN;
      pc      <= RESET_PC;
      ir_q    <= NOP_WORD;
      ir_pc_q <= '0;
      vld_q   <= 1'b0;
      sp      <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.halt_req) begin
            // PC holds so the pending fetch is replayed after resume.
            state <= ST_HALT;
            ir_q  <= NOP_WORD;
            vld_q <= 1'b0;
          end else if (bus.ret) begin
            ir_q  <= NOP_WORD;
            vld_q <= 1'b0;
            if (stk_empty) begin
              state <= ST_FAULT;
            end else begin
              pc <= stk[pop_idx];
              sp <= sp_dec;
            end
          end else if (bus.call) begin
            pc    <= bus.tgt;
            ir_q  <= NOP_WORD;
            vld_q <= 1'b0;
            if (stk_full) ovf_q <= 1'b1;
            else          sp    <= sp + 1'b1;
          end else if (bus.jmp) begin
            pc    <= bus.tgt;
            ir_q  <= NOP_WORD;
            vld_q <= 1'b0;
          end else if (!bus.stall) begin
            ir_q    <= bus.mem_instr;
            ir_pc_q <= pc;
            vld_q   <= 1'b1;
            pc      <= pc + 1'b1;
          end
        end
        ST_HALT: begin
          vld_q <= 1'b0;
          if (bus.resume && !bus.halt_req) state <= ST_RUN;
        end
        default: begin
          // FAULT is absorbing; only reset leaves it.
          vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc_addr  = pc;
  assign bus.ir       = ir_q;
  assign bus.ir_pc    = ir_pc_q;
  assign bus.ir_valid = vld_q;
  assign bus.halted   = (state == ST_HALT);
  assign bus.fault    = (state == ST_FAULT);
  assign bus.stk_ovf  = ovf_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a behavioural program memory feeds
// mem_instr from pc_addr; expected values are written out by hand.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] mem [4096];

  instr_fetch_unit_if #(.ADDR_W(12), .INSTR_W(16)) bus ();

  instr_fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  assign bus.mem_instr = mem[bus.pc_addr];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance one clock, then settle past the edge before sampling
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_in();
    bus.stall = 0; bus.jmp = 0; bus.call = 0; bus.ret = 0;
    bus.tgt = '0; bus.halt_req = 0; bus.resume = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick(2);
    rst_n = 1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h5000 | 16'(i);
    mem[0] = 16'hA0A0; mem[1] = 16'hB0B1; mem[2] = 16'hC0C2; mem[3] = 16'hD0D3;
    clr_in();

    // reset state
    tick(2);
    chk("rst_pc",    bus.pc_addr,  32'h000);
    chk("rst_ir",    bus.ir,       32'hFFFF);
    chk("rst_irpc",  bus.ir_pc,    32'h000);
    chk("rst_vld",   bus.ir_valid, 32'h0);
    chk("rst_halt",  bus.halted,   32'h0);
    chk("rst_fault", bus.fault,    32'h0);
    chk("rst_ovf",   bus.stk_ovf,  32'h0);

    // T1 sequential
    rst_n = 1;
    chk("t1_pc0",  bus.pc_addr,  32'h000);
    tick();
    chk("t1_irA",  bus.ir,       32'hA0A0);
    chk("t1_vld1", bus.ir_valid, 32'h1);
    chk("t1_pc1",  bus.pc_addr,  32'h001);
    tick();
    chk("t1_irB",  bus.ir,       32'hB0B1);
    chk("t1_irpc1",bus.ir_pc,    32'h001);
    chk("t1_pc2",  bus.pc_addr,  32'h002);
    tick();
    chk("t1_irC",  bus.ir,       32'hC0C2);
    chk("t1_pc3",  bus.pc_addr,  32'h003);

    // T2 jmp while IR holds addr 5
    tick(3);
    chk("t2_irpc5", bus.ir_pc, 32'h005);
    bus.jmp = 1; bus.tgt = 12'h020;
    tick();
    clr_in();
    chk("t2_sq_ir",  bus.ir,       32'hFFFF);
    chk("t2_sq_vld", bus.ir_valid, 32'h0);
    chk("t2_pc",     bus.pc_addr,  32'h020);
    tick();
    chk("t2_ir",     bus.ir,       32'h5020);
    chk("t2_irpc",   bus.ir_pc,    32'h020);

    // T3 call/ret nest
    do_reset();
    tick(5);
    chk("t3_irpc4", bus.ir_pc, 32'h004);
    bus.call = 1; bus.tgt = 12'hFF1;
    tick();
    clr_in();
    chk("t3_pc_ff1", bus.pc_addr, 32'hFF1);
    tick(2);
    chk("t3_irpc_ff2", bus.ir_pc, 32'hFF2);
    bus.call = 1; bus.tgt = 12'h100;
    tick();
    clr_in();
    chk("t3_pc_100", bus.pc_addr, 32'h100);
    tick();
    bus.ret = 1;
    tick();
    chk("t3_ret1", bus.pc_addr, 32'hFF3);
    tick();
    bus.ret = 0;
    chk("t3_ret2", bus.pc_addr, 32'h005);
    chk("t3_ovf",  bus.stk_ovf, 32'h0);
    tick();
    chk("t3_fetch5", bus.ir, 32'h5005);
    bus.ret = 1;                          // stack should now be empty
    tick();
    clr_in();
    chk("t3_sp0_fault", bus.fault, 32'h1);

    // T4 overflow then drain to underflow
    do_reset();
    bus.call = 1; bus.tgt = 12'h200; tick(); clr_in(); tick();
    bus.call = 1; bus.tgt = 12'h300; tick(); clr_in(); tick();
    bus.call = 1; bus.tgt = 12'h400; tick(); clr_in(); tick();
    bus.call = 1; bus.tgt = 12'h500; tick(); clr_in();
    chk("t4_ovf0", bus.stk_ovf, 32'h0);
    tick();
    bus.call = 1; bus.tgt = 12'h600; tick(); clr_in();
    chk("t4_ovf1",  bus.stk_ovf, 32'h1);
    chk("t4_pc600", bus.pc_addr, 32'h600);
    bus.ret = 1;
    tick(); chk("t4_r1", bus.pc_addr, 32'h401);
    tick(); chk("t4_r2", bus.pc_addr, 32'h301);
    tick(); chk("t4_r3", bus.pc_addr, 32'h201);
    tick(); chk("t4_r4", bus.pc_addr, 32'h001);
    chk("t4_nofault", bus.fault, 32'h0);
    tick(); clr_in();
    chk("t4_fault",  bus.fault,    32'h1);
    chk("t4_frozen", bus.pc_addr,  32'h001);
    chk("t4_vld",    bus.ir_valid, 32'h0);
    chk("t4_ovf_st", bus.stk_ovf,  32'h1);
    bus.jmp = 1; bus.tgt = 12'h0AA; bus.resume = 1;
    tick(3); clr_in();
    chk("t4_absorb", bus.fault,   32'h1);
    chk("t4_pc_hld", bus.pc_addr, 32'h001);
    do_reset();
    bus.ret = 1; tick(); clr_in();
    chk("t4_ufl_rst", bus.fault,   32'h1);
    chk("t4_ufl_pc",  bus.pc_addr, 32'h000);

    // T5 stall / halt
    do_reset();
    tick(2);
    bus.stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_st_ir", bus.ir,      32'hB0B1);
      chk("t5_st_pc", bus.pc_addr, 32'h002);
    end
    bus.jmp = 1; bus.tgt = 12'h030;       // redirect beats stall
    tick(); clr_in();
    chk("t5_st_jmp", bus.pc_addr, 32'h030);
    bus.jmp = 1; bus.tgt = 12'h007; tick(); clr_in();
    chk("t5_pc7", bus.pc_addr, 32'h007);
    bus.halt_req = 1; bus.jmp = 1; bus.tgt = 12'h123;
    tick(); clr_in();
    chk("t5_halted", bus.halted,   32'h1);
    chk("t5_hpc",    bus.pc_addr,  32'h007);
    chk("t5_hvld",   bus.ir_valid, 32'h0);
    bus.halt_req = 1; bus.resume = 1;
    tick(); clr_in();
    chk("t5_hr_both", bus.halted, 32'h1);
    bus.resume = 1;
    tick(); clr_in();
    chk("t5_resumed", bus.halted,  32'h0);
    chk("t5_rpc",     bus.pc_addr, 32'h007);
    tick();
    chk("t5_ir7",   bus.ir,       32'h5007);
    chk("t5_irpc7", bus.ir_pc,    32'h007);
    chk("t5_vld",   bus.ir_valid, 32'h1);

    // T6 wrap, then reset mid-call
    bus.jmp = 1; bus.tgt = 12'hFFE; tick(); clr_in();
    tick(2);
    chk("t6_wrap_pc", bus.pc_addr, 32'h000);
    chk("t6_irFFF",   bus.ir,      32'h5FFF);
    bus.call = 1; bus.tgt = 12'h444; tick();  // stack now non-empty
    bus.tgt = 12'h555; rst_n = 0;
    tick();
    chk("t6_rpc",  bus.pc_addr,  32'h000);
    chk("t6_rir",  bus.ir,       32'hFFFF);
    chk("t6_rvld", bus.ir_valid, 32'h0);
    chk("t6_rovf", bus.stk_ovf,  32'h0);
    clr_in(); rst_n = 1;
    bus.ret = 1; tick(); clr_in();
    chk("t6_sp0", bus.fault, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
